hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the STALL/FLUSH inputs of the IF/ID register, the PC hold and the ID/EX bubble insert.
- Detects three hazard classes:
  - load-use hazards;
  - branch-operand hazards, since branches resolve in ID;
  - HI/LO busy hazards from a multi-cycle multiply/divide unit.
- Resolves taken-branch flushes and keeps saturating stall/flush performance counters.

---
 rtl/hazard_unit.sv | 66 ++++++
 tb/tb_hazard_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: load-use, branch-operand and HI/LO stall detection with taken-branch flush
// and saturating stall/flush event counters for the 5-stage MIPS pipeline.
module hazard_unit #(
   parameter int MULDIV_LATENCY = 4,
   parameter int CNT_W          = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_IsBranch,
   input  logic             ID_UsesHiLo,
   input  logic             ID_BranchTaken,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_WriteReg,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_WriteReg,
   input  logic             EX_StartMulDiv,
   output logic             STALL_PC,
   output logic             STALL_IFID,
   output logic             FLUSH_IFID,
   output logic             FLUSH_IDEX,
   output logic             MulDivBusy,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);
   logic [2:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             ex_match, mem_match, stall, flush;
   always_comb begin
      ex_match  = (EX_WriteReg != 5'd0) &&
                  ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg));
      mem_match = (MEM_WriteReg != 5'd0) &&
                  ((ID_UsesRs && ID_Rs == MEM_WriteReg) || (ID_UsesRt && ID_Rt == MEM_WriteReg));
      // Outputs are forced low while reset is held, whatever the inputs say.
      stall = !RESET && ((EX_MemRead && ex_match) ||
                         (ID_IsBranch && EX_RegWrite && ex_match) ||
                         (ID_IsBranch && MEM_MemRead && mem_match) ||
                         (ID_UsesHiLo && (EX_StartMulDiv || md_cnt_q > 3'd1)));
      flush = !RESET && ID_BranchTaken && !stall;
      md_cnt_d    = EX_StartMulDiv ? 3'(MULDIV_LATENCY) : (md_cnt_q != 3'd0) ? md_cnt_q - 3'd1 : md_cnt_q;
      stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         md_cnt_q    <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign STALL_PC    = stall;
   assign STALL_IFID  = stall;
   assign FLUSH_IDEX  = stall;
   assign FLUSH_IFID  = flush;
   assign MulDivBusy  = !RESET && md_cnt_q != 3'd0;
   assign StallCycles = stall_cnt_q;
   assign FlushCount  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with hand-computed expectations for hazard_unit
// (MULDIV_LATENCY=4, CNT_W=16).
module tb_hazard_unit;
   logic        CLOCK = 1'b0, RESET = 1'b1;
   logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
   logic        ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_UsesHiLo, ID_BranchTaken;
   logic        EX_MemRead, EX_RegWrite, MEM_MemRead, EX_StartMulDiv;
   logic        STALL_PC, STALL_IFID, FLUSH_IFID, FLUSH_IDEX, MulDivBusy;
   logic [15:0] StallCycles, FlushCount;
   int          checks = 0, failures = 0;
   hazard_unit #(.MULDIV_LATENCY(4), .CNT_W(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
      .ID_UsesHiLo(ID_UsesHiLo), .ID_BranchTaken(ID_BranchTaken),
      .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
      .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .EX_StartMulDiv(EX_StartMulDiv),
      .STALL_PC(STALL_PC), .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID),
      .FLUSH_IDEX(FLUSH_IDEX), .MulDivBusy(MulDivBusy),
      .StallCycles(StallCycles), .FlushCount(FlushCount)
   );
   always #5 CLOCK = ~CLOCK;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic clr();
      {ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg} = '0;
      {ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_UsesHiLo, ID_BranchTaken} = '0;
      {EX_MemRead, EX_RegWrite, MEM_MemRead, EX_StartMulDiv} = '0;
   endtask
   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask
   initial begin
      clr();
      EX_MemRead = 1; EX_WriteReg = 5; ID_Rs = 5; ID_UsesRs = 1;
      #3;
      chk("rst_stall", 32'(STALL_PC), 0);
      chk("rst_flush_idex", 32'(FLUSH_IDEX), 0);
      chk("rst_sc", 32'(StallCycles), 0);
      chk("rst_fc", 32'(FlushCount), 0);
      clr();
      step(); RESET = 0;
      // load-use
      EX_MemRead = 1; EX_WriteReg = 5; ID_Rs = 5; ID_UsesRs = 1; #1;
      chk("lu_stall_pc", 32'(STALL_PC), 1);
      chk("lu_stall_ifid", 32'(STALL_IFID), 1);
      chk("lu_flush_idex", 32'(FLUSH_IDEX), 1);
      chk("lu_sc_before", 32'(StallCycles), 0);
      step(); clr(); #1;
      chk("lu_sc_after", 32'(StallCycles), 1);
      chk("lu_released", 32'(STALL_PC), 0);
      EX_MemRead = 1; EX_WriteReg = 7; ID_Rt = 7; ID_UsesRt = 1; #1;
      chk("lu_rt", 32'(STALL_PC), 1);
      ID_UsesRt = 0; ID_Rs = 7; #1;
      chk("lu_uses_clear", 32'(STALL_PC), 0);
      EX_WriteReg = 0; ID_Rs = 0; ID_UsesRs = 1; #1;
      chk("lu_reg0", 32'(STALL_PC), 0);
      clr();
      // branch-on-load: two stalls, then flush
      EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 3; ID_Rs = 3; ID_UsesRs = 1;
      ID_IsBranch = 1; ID_BranchTaken = 1; #1;
      chk("bl_c1_stall", 32'(STALL_PC), 1);
      chk("bl_c1_flush", 32'(FLUSH_IFID), 0);
      step();
      EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0; MEM_MemRead = 1; MEM_WriteReg = 3; #1;
      chk("bl_c2_stall", 32'(STALL_PC), 1);
      chk("bl_c2_flush", 32'(FLUSH_IFID), 0);
      step();
      MEM_MemRead = 0; MEM_WriteReg = 0; #1;
      chk("bl_c3_stall", 32'(STALL_PC), 0);
      chk("bl_c3_flush", 32'(FLUSH_IFID), 1);
      step();
      chk("bl_fc", 32'(FlushCount), 1);
      chk("bl_sc", 32'(StallCycles), 3);
      clr();
      // taken branch without dependency; then branch on ALU result in EX
      ID_IsBranch = 1; ID_BranchTaken = 1; ID_Rs = 4; ID_UsesRs = 1;
      EX_RegWrite = 1; EX_WriteReg = 6; #1;
      chk("br_flush", 32'(FLUSH_IFID), 1);
      chk("br_nostall", 32'(STALL_PC), 0);
      step();
      chk("br_fc", 32'(FlushCount), 2);
      EX_WriteReg = 4; #1;
      chk("bex_stall", 32'(STALL_PC), 1);
      chk("bex_noflush", 32'(FLUSH_IFID), 0);
      clr();
      // MULT in EX, MFLO in ID
      EX_StartMulDiv = 1; ID_UsesHiLo = 1; #1;
      chk("md_start_stall", 32'(STALL_PC), 1);
      chk("md_start_busy", 32'(MulDivBusy), 0);
      step();
      EX_StartMulDiv = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("md_stall", 32'(STALL_PC), 1);
         chk("md_busy", 32'(MulDivBusy), 1);
         step();
      end
      chk("md_release", 32'(STALL_PC), 0);
      chk("md_busy_last", 32'(MulDivBusy), 1);
      chk("md_sc", 32'(StallCycles), 7);
      ID_UsesHiLo = 0;
      step();
      chk("md_idle", 32'(MulDivBusy), 0);
      // back-to-back MULT reloads
      EX_StartMulDiv = 1; step(); step();
      EX_StartMulDiv = 0; ID_UsesHiLo = 1;
      step(); step();
      chk("md_reload_stall", 32'(STALL_PC), 1);
      step();
      chk("md_reload_release", 32'(STALL_PC), 0);
      chk("md_reload_sc", 32'(StallCycles), 10);
      ID_UsesHiLo = 0; step();
      // async reset with count=3 and a stall pending
      EX_StartMulDiv = 1; step();
      EX_StartMulDiv = 0; ID_UsesHiLo = 1; step();
      chk("ar_pre_stall", 32'(STALL_PC), 1);
      #2 RESET = 1; #1;
      chk("ar_stall", 32'(STALL_PC), 0);
      chk("ar_flush_idex", 32'(FLUSH_IDEX), 0);
      chk("ar_busy", 32'(MulDivBusy), 0);
      chk("ar_sc", 32'(StallCycles), 0);
      chk("ar_fc", 32'(FlushCount), 0);
      @(posedge CLOCK); #2 RESET = 0; #1;
      chk("ar_post_stall", 32'(STALL_PC), 0);
      chk("ar_post_busy", 32'(MulDivBusy), 0);
      clr();
      // saturation of StallCycles
      step();
      EX_MemRead = 1; EX_WriteReg = 9; ID_Rs = 9; ID_UsesRs = 1;
      repeat (65534) @(posedge CLOCK);
      #1;
      chk("sat_almost", 32'(StallCycles), 32'hFFFE);
      repeat (5) @(posedge CLOCK);
      #1;
      chk("sat_full", 32'(StallCycles), 32'hFFFF);
      repeat (3) @(posedge CLOCK);
      #1;
      chk("sat_hold", 32'(StallCycles), 32'hFFFF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
